// File: rtl/rr_grant_sink_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_grant_sink_if : grant, source and output channel bundle           |
// | Rev 1.0 - initial release (timeout_err only with                     |
// |           RR_GRANT_SINK_TIMEOUT_EN)                                  |
// +----------------------------------------------------------------------+
interface rr_grant_sink_if #(
  parameter int DW = 8
);
  logic [3:0]      gnt;
  logic [3:0]      src_valid;
  logic [4*DW-1:0] src_data;
  logic [3:0]      src_last;
  logic [3:0]      src_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic [1:0]      owner;
  logic            busy;
  logic [3:0]      done;
`ifdef RR_GRANT_SINK_TIMEOUT_EN
  logic            timeout_err;

  modport slave (
    input  gnt, src_valid, src_data, src_last, out_ready,
    output src_ready, out_valid, out_data, out_last, owner, busy, done, timeout_err
  );
  modport master (
    output gnt, src_valid, src_data, src_last, out_ready,
    input  src_ready, out_valid, out_data, out_last, owner, busy, done, timeout_err
  );
`else
  modport slave (
    input  gnt, src_valid, src_data, src_last, out_ready,
    output src_ready, out_valid, out_data, out_last, owner, busy, done
  );
  modport master (
    output gnt, src_valid, src_data, src_last, out_ready,
    input  src_ready, out_valid, out_data, out_last, owner, busy, done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/rr_grant_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_grant_sink : latches the arbiter's grant as owner, forwards its   |
// | burst through one registered valid/ready channel, pulses done.       |
// | Optional idle-owner abort: RR_GRANT_SINK_TIMEOUT_EN                  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module rr_grant_sink #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input wire             clk,
  input wire             rst,
  rr_grant_sink_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    owner_q, owner_nx, low_idx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          out_valid_q, out_valid_nx;
  logic          out_last_q, out_last_nx;
  logic [DW-1:0] out_data_q, out_data_nx;
  logic          busy_q, busy_nx;
  logic [3:0]    done_q, done_nx;
  logic          own_valid, own_last, xfer_ready, accept, drain;
  logic [DW-1:0] own_data;

`ifdef RR_GRANT_SINK_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt, idle_nx;
  logic          timeout_err_q, timeout_err_nx;
`endif

  if (MAX_BURST < 1 || TIMEOUT < 1) begin : g_param_check
    $error("rr_grant_sink: MAX_BURST and TIMEOUT must be >= 1");
  end

  always_comb begin
    low_idx   = 2'd0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    // Descending scan so the lowest set grant bit wins on multi-hot.
    for (int i = 3; i >= 0; i--) begin
      if (bus.gnt[i]) low_idx = 2'(i);
    end
    for (int i = 0; i < 4; i++) begin
      if (owner_q == 2'(i)) begin
        own_valid = bus.src_valid[i];
        own_last  = bus.src_last[i];
        own_data  = bus.src_data[i*DW +: DW];
      end
    end
  end

  assign drain      = out_valid_q && bus.out_ready;
  assign xfer_ready = (state == XFER) && (!out_valid_q || bus.out_ready);
  assign accept     = xfer_ready && own_valid;

  always_comb begin
    state_nx     = state;
    owner_nx     = owner_q;
    cnt_nx       = cnt;
    out_valid_nx = out_valid_q;
    out_data_nx  = out_data_q;
    out_last_nx  = out_last_q;
    done_nx      = 4'b0000;
`ifdef RR_GRANT_SINK_TIMEOUT_EN
    idle_nx        = idle_cnt;
    timeout_err_nx = timeout_err_q;
`endif
    case (state)
      IDLE: begin
        // A set done means the requester is dropping req this cycle.
        if ((bus.gnt != 4'b0000) && (done_q == 4'b0000)) begin
          owner_nx = low_idx;
          cnt_nx   = '0;
          state_nx = XFER;
`ifdef RR_GRANT_SINK_TIMEOUT_EN
          idle_nx  = '0;
`endif
        end
      end
      XFER: begin
        if (accept) begin
          out_data_nx  = own_data;
          out_valid_nx = 1'b1;
          out_last_nx  = own_last || (cnt == CW'(MAX_BURST - 1));
          cnt_nx       = cnt + CW'(1);
`ifdef RR_GRANT_SINK_TIMEOUT_EN
          idle_nx      = '0;
`endif
          if (out_last_nx) state_nx = DRAIN;
        end else begin
          if (drain) out_valid_nx = 1'b0;
`ifdef RR_GRANT_SINK_TIMEOUT_EN
          idle_nx = idle_cnt + IW'(1);
          if (idle_cnt == IW'(TIMEOUT - 1)) begin
            timeout_err_nx = 1'b1;
            if (out_valid_nx) begin
              out_last_nx = 1'b1;
              state_nx    = DRAIN;
            end else begin
              done_nx  = 4'b0001 << owner_q;
              state_nx = IDLE;
            end
          end
`endif
        end
      end
      DRAIN: begin
        if (drain) begin
          out_valid_nx = 1'b0;
          done_nx      = 4'b0001 << owner_q;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      owner_q     <= 2'd0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 4'b0000;
`ifdef RR_GRANT_SINK_TIMEOUT_EN
      idle_cnt      <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state       <= state_nx;
      owner_q     <= owner_nx;
      cnt         <= cnt_nx;
      out_valid_q <= out_valid_nx;
      out_data_q  <= out_data_nx;
      out_last_q  <= out_last_nx;
      busy_q      <= busy_nx;
      done_q      <= done_nx;
`ifdef RR_GRANT_SINK_TIMEOUT_EN
      idle_cnt      <= idle_nx;
      timeout_err_q <= timeout_err_nx;
`endif
    end
  end

  assign bus.src_ready = xfer_ready ? (4'b0001 << owner_q) : 4'b0000;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef RR_GRANT_SINK_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rr_grant_sink : directed + random stimulus against a burst model  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_rr_grant_sink;
  localparam int MB = 4;
  localparam int TO = 5;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  rr_grant_sink_if #(.DW(8)) bus ();

  rr_grant_sink #(.DW(8), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Burst-level reference: phase 0 idle, 1 collecting beats, 2 waiting for drain.
  int         m_ph, m_cnt, m_idle;
  logic [1:0] m_owner;
  bit         m_ov, m_ol, m_terr, m_dr, m_take, model_on;
  logic [7:0] m_od;
  logic [3:0] m_done, m_nd, exp_rdy;

  function automatic logic [1:0] lowest(input logic [3:0] g);
    int k = 0;
    while (k < 3 && !g[k]) k++;
    return 2'(k);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_ph = 0; m_owner = 0; m_cnt = 0; m_ov = 0; m_od = 0; m_ol = 0;
      m_done = 0; m_idle = 0; m_terr = 0;
    end else begin
      m_dr = m_ov && bus.out_ready;
      m_nd = 4'b0;
      if (m_ph == 0) begin
        if (bus.gnt != 0 && m_done == 0) begin
          m_owner = lowest(bus.gnt); m_cnt = 0; m_idle = 0; m_ph = 1;
        end
      end else if (m_ph == 1) begin
        m_take = (!m_ov || bus.out_ready) && bus.src_valid[m_owner];
        if (m_take) begin
          m_od = bus.src_data[m_owner*8 +: 8];
          m_ol = bus.src_last[m_owner] || (m_cnt == MB - 1);
          m_ov = 1; m_cnt++; m_idle = 0;
          if (m_ol) m_ph = 2;
        end else begin
          if (m_dr) m_ov = 0;
`ifdef RR_GRANT_SINK_TIMEOUT_EN
          m_idle++;
          if (m_idle == TO) begin
            m_terr = 1;
            if (m_ov) begin m_ol = 1; m_ph = 2; end
            else begin m_nd[m_owner] = 1'b1; m_ph = 0; end
          end
`endif
        end
      end else if (m_dr) begin
        m_ov = 0; m_nd[m_owner] = 1'b1; m_ph = 0;
      end
      m_done = m_nd;
    end
    model_on = 1;
  end

  logic [8:0] outlog[$];
  logic [3:0] donelog[$];

  always @(negedge clk) begin
    if (model_on) begin
      exp_rdy = (m_ph == 1 && (!m_ov || bus.out_ready)) ? (4'b0001 << m_owner) : 4'b0000;
      chk("out_valid", bus.out_valid, m_ov);
      chk("out_data", bus.out_data, m_od);
      chk("out_last", bus.out_last, m_ol);
      chk("owner", bus.owner, m_owner);
      chk("busy", bus.busy, m_ph != 0);
      chk("done", bus.done, m_done);
      chk("src_ready", bus.src_ready, exp_rdy);
`ifdef RR_GRANT_SINK_TIMEOUT_EN
      chk("timeout_err", bus.timeout_err, m_terr);
`endif
    end
    if (bus.out_valid && bus.out_ready) outlog.push_back({bus.out_last, bus.out_data});
    if (bus.done != 0) donelog.push_back(bus.done);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.gnt = 0; bus.src_valid = 0; bus.src_data = 0; bus.src_last = 0; bus.out_ready = 1;
  endtask

  task automatic burst(input int src, input int nbeats, input logic [7:0] d0,
                       input int last_at, input logic [31:0] pat, output int taken);
    int beat = 0;
    int cyc  = 0;
    bit seen = 0;
    bit acc;
    outlog.delete();
    donelog.delete();
    bus.gnt = 4'b0001 << src;
    step();
    bus.gnt = 0;
    while (!seen && cyc < 100) begin
      bus.src_valid = (beat < nbeats) ? (4'b0001 << src) : 4'b0000;
      bus.src_data  = 0;
      bus.src_data[src*8 +: 8] = d0 + 8'(beat);
      bus.src_last  = (beat == last_at) ? (4'b0001 << src) : 4'b0000;
      bus.out_ready = pat[cyc % 32];
      @(negedge clk);
      acc  = bus.src_ready[src] && bus.src_valid[src];
      seen = (bus.done != 0);
      step();
      if (acc) beat++;
      cyc++;
    end
    if (!seen) chk("burst_done_wait", 0, 1);
    idle_inputs();
    step();
    taken = beat;
  endtask

  initial begin
    int taken;
    int waited;
    rst = 1'b0;
    idle_inputs();
    bus.gnt = 4'b0100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_owner", bus.owner, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    #4;
    rst = 1'b1;
    bus.gnt = 0;
    step();
    @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);
    step();

    // Single burst on requester 1
    burst(1, 3, 8'hA1, 2, 32'hFFFF_FFFF, taken);
    chk("sb_count", outlog.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("sb_beat", (i < outlog.size()) ? outlog[i] : 9'h1FF, {i == 2, 8'hA1 + 8'(i)});
    chk("sb_done", (donelog.size() == 1) ? donelog[0] : 4'hF, 4'b0010);
    chk("sb_busy_end", bus.busy, 0);

    // Same burst with two stalled output cycles
    burst(1, 3, 8'hA1, 2, 32'hFFFF_FFF3, taken);
    chk("bp_count", outlog.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("bp_beat", (i < outlog.size()) ? outlog[i] : 9'h1FF, {i == 2, 8'hA1 + 8'(i)});
    chk("bp_taken", taken, 3);

    // Forced termination at MAX_BURST
    burst(0, 6, 8'h10, -1, 32'hFFFF_FFFF, taken);
    chk("ft_taken", taken, MB);
    chk("ft_count", outlog.size(), MB);
    for (int i = 0; i < MB; i++)
      chk("ft_beat", (i < outlog.size()) ? outlog[i] : 9'h1FF, {i == MB - 1, 8'h10 + 8'(i)});
    chk("ft_done", (donelog.size() == 1) ? donelog[0] : 4'hF, 4'b0001);

    // Multi-hot grant and non-owner isolation
    bus.gnt = 4'b1010;
    step();
    bus.gnt = 0;
    bus.src_valid = 4'b1111;
    bus.src_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.src_last  = 4'b1111;
    @(negedge clk);
    chk("mh_owner", bus.owner, 1);
    chk("mh_src_ready", bus.src_ready, 4'b0010);
    step();
    bus.src_valid = 0;
    bus.src_last  = 0;
    @(negedge clk);
    chk("mh_data", bus.out_data, 8'h22);
    chk("mh_last", bus.out_last, 1);
    waited = 0;
    while (bus.done == 0 && waited < 10) begin step(); @(negedge clk); waited++; end
    chk("mh_done", bus.done, 4'b0010);
    step();
    step();

`ifdef RR_GRANT_SINK_TIMEOUT_EN
    // Owner 2 sends one beat then stalls
    bus.gnt = 4'b0100;
    step();
    bus.gnt = 0;
    bus.src_valid = 4'b0100;
    bus.src_data  = 32'h005A_0000;
    step();
    bus.src_valid = 0;
    waited = 0;
    @(negedge clk);
    while (bus.done == 0 && waited < 20) begin step(); @(negedge clk); waited++; end
    chk("to_latency", waited, TO);
    chk("to_done", bus.done, 4'b0100);
    chk("to_err", bus.timeout_err, 1);
    repeat (3) step();
    @(negedge clk);
    chk("to_err_sticky", bus.timeout_err, 1);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("to_err_cleared", bus.timeout_err, 0);
    step();
`endif

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rst           = ($urandom_range(0, 299) != 0);
      bus.gnt       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      bus.src_valid = 4'($urandom);
      bus.src_data  = $urandom;
      bus.src_last  = 4'($urandom) & 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b1;
    idle_inputs();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rr_grant_sink.md
Name: rr_grant_sink

Overview:
- Downstream consumer of the 4-requester round-robin arbiter's one-hot `gnt`.
- Latches the granted requester as owner and routes that requester's data burst through a single registered output channel with valid/ready flow control.
- Pulses a per-requester `done` when the burst has fully drained, so the requester can drop `req` and the arbiter can rotate.

Parameters:
- DW, 8, data width per requester.
- MAX_BURST, 16, maximum beats per ownership; the burst is force-terminated at this count (≥1).
- TIMEOUT, 64, idle-owner cycle limit; used only with the optional feature (≥1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- gnt  in  4  one-hot grant from the arbiter (0 = no grant).
- src_valid  in  4  per-requester beat valid.
- src_data  in  4*DW  per-requester data; requester i occupies bits [i*DW +: DW].
- src_last  in  4  per-requester last-beat flag.
- src_ready  out  4  per-requester ready; combinational, only the owner's bit can be 1.
- out_valid  out  1  output beat valid (registered).
- out_data  out  DW  output beat data (registered).
- out_last  out  1  output last-beat flag (registered).
- out_ready  in  1  downstream ready.
- owner  out  2  index of the current owner (registered).
- busy  out  1  high in XFER and DRAIN.
- done  out  4  one-cycle pulse on the owner's bit at burst end (registered).

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; out_valid, out_data, out_last, owner, busy, done, beat counter all 0. Reset mid-burst aborts the burst immediately with no `done` pulse.
- States: IDLE, XFER, DRAIN.
- IDLE:
  - `src_ready`=0.
  - If `gnt`≠0 and `done`==0: owner ← index of the lowest set bit of `gnt` (multi-hot resolves to the lowest bit); counter ← 0; go to XFER.
  - `gnt` is ignored while `done` is high, because the requester drops `req` in that cycle.
- XFER:
  - `src_ready[owner]` = !out_valid || out_ready; other bits 0.
  - Beat accepted when `src_valid[owner]` && `src_ready[owner]`. On accept:
    - out_data ← the owner's slice; out_valid ← 1.
    - out_last ← src_last[owner] || (counter==MAX_BURST-1).
    - counter increments.
  - If the accepted beat has out_last=1, go to DRAIN.
  - Valid on non-owner requesters is ignored.
- Output register: when out_valid && out_ready and no new beat is loaded that cycle, out_valid ← 0. Simultaneous drain and load keeps out_valid=1 with the new data, giving full throughput of 1 beat/cycle.
- Latency: source beat to out_valid is 1 cycle.
- DRAIN:
  - `src_ready`=0.
  - When out_valid && out_ready: out_valid ← 0, done[owner] ← 1 for one cycle, go to IDLE.
- `busy` is registered and high exactly when state is XFER or DRAIN. `owner` holds its value after IDLE until the next capture.
- `done` and `out_valid` are never both asserted for the same owner's burst after DRAIN.
- A 1-beat burst takes 1 cycle in IDLE capture, then the beat, drain and done pulse follow.

Optional Feature:
- Macro: RR_GRANT_SINK_TIMEOUT_EN.
- Defined:
  - An idle counter increments in XFER on every cycle without an accepted beat and clears on each accept.
  - When it reaches TIMEOUT, the burst aborts: if out_valid is set, the block goes to DRAIN with out_last forced to 1 on the pending beat; otherwise it pulses done[owner] and returns to IDLE directly.
  - Adds output `timeout_err` (1 bit): sticky, set on abort, cleared only by reset.
- Not defined: no idle counter and no `timeout_err` port; the owner may stall indefinitely.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, gnt=4'b0100 during reset → all outputs 0, state IDLE after release.
- Single burst: gnt=0010, src1 sends 3 beats 0xA1,0xA2,0xA3 (last on the 3rd), out_ready=1 → out_data A1,A2,A3 on consecutive cycles with out_last on A3, then done=0010 for one cycle, busy drops.
- Backpressure: same burst with out_ready low for 2 cycles mid-burst → src_ready[1]=0 while the register is full, no beat lost or duplicated, order preserved.
- Forced termination: MAX_BURST=4, src0 streams 6 beats with no last → out_last on the 4th beat, done=0001, beats 5–6 not accepted.
- Non-owner isolation and multi-hot: gnt=1010 → owner=1; src_valid=1111 → only src_ready[1] rises, only src1 data appears.
- Timeout (macro on, TIMEOUT=5): owner 2 sends one beat, then stalls with out_ready=1 → after 5 idle cycles done=0100, timeout_err=1 and stays 1 until reset.
